lights_game_ctrl: RTL and testbench
===================================

LIGHTS_GAME_CTRL -- requirements
Module: lights_game_ctrl

Interface
REQ-001 Parameter TICK_CYCLES, default 50000000, clock cycles per one-second countdown tick.
REQ-002 Parameter COUNTDOWN, default 10, seconds per round (range 1..99).
REQ-003 clk  input  1  rising-edge system clock.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  level; sampled every cycle, begins a new round.
REQ-006 switch  input  8  player switches, already synchronous to clk.
REQ-007 light  output  8  lamp pattern, registered.
REQ-008 tries  output  8  accepted presses this round, registered, binary.
REQ-009 time_left  output  8  remaining seconds, registered, binary.
REQ-010 disp_val  output  8  value for the two-digit decoder, registered, 0..99.
REQ-011 state  output  2  IDLE=0, PLAY=1, WIN=2, LOSE=3.
REQ-012 finish  output  1  high while state==WIN.
REQ-013 timeout  output  1  high while state==LOSE.

Function
REQ-014 An 8-bit Fibonacci LFSR (taps 8,6,5,4; shift left, feedback into bit0) SHALL advance every cycle in all states and never hold 0.
REQ-015 Press detect SHALL be press = switch & ~switch_q, with switch_q <= switch every cycle.
REQ-016 If press has several bits set in one cycle, only the lowest index i SHALL be processed; the others are discarded.
REQ-017 A processed press at index i SHALL toggle light[i], light[i-1] if i>=1, light[i+1] if i<=6, all in the same cycle.
REQ-018 Each processed press SHALL increment tries by 1, saturating at 99.
REQ-019 Presses SHALL be processed only in PLAY; ignored in IDLE, WIN and LOSE.
REQ-020 start in IDLE, WIN or LOSE SHALL, next cycle: state=PLAY, light=current LFSR value, tries=0, time_left=COUNTDOWN, tick counter=0.
REQ-021 start in PLAY SHALL be ignored.
REQ-022 In PLAY the tick counter SHALL count 0..TICK_CYCLES-1 and wrap; on the wrap cycle time_left SHALL decrement by 1.
REQ-023 The tick counter SHALL hold at 0 outside PLAY.
REQ-024 PLAY->WIN when the post-press light value is 8'h00; state, light and tries update in the same cycle.
REQ-025 PLAY->LOSE on the wrap cycle with time_left==1; time_left becomes 0.
REQ-026 Winning press and final wrap in the same cycle: WIN SHALL take priority; time_left stays 1.
REQ-027 WIN and LOSE SHALL freeze light, tries and time_left until start or reset.
REQ-028 disp_val SHALL equal 0 in IDLE, time_left in PLAY, tries in WIN and LOSE, updated one cycle after its source.
REQ-029 finish and timeout SHALL decode combinationally from the registered state; never both high.

Reset
REQ-030 On reset: state=IDLE, light=0, tries=0, time_left=0, disp_val=0, finish=0, timeout=0, tick counter=0, LFSR=8'hA5.
REQ-031 On reset switch_q SHALL load 8'hFF, so a switch held through reset gives no press until released and raised again.
REQ-032 Reset SHALL take priority over start and presses in the same cycle and SHALL abort a round in progress.

Verification (TICK_CYCLES=4, COUNTDOWN=3)
REQ-033 Reset, one start pulse -> next cycle state=1, light=LFSR value (nonzero), tries=0, time_left=3, disp_val=3 one cycle later.
REQ-034 light=8'b00000010, raise switch[0] -> light=8'b00000001, tries=1; holding switch[0] gives no further change.
REQ-035 light=8'b00000111, raise switch[1] -> light=0, state=2, finish=1; disp_val=1 next cycle; later start gives state=1, tries=0.
REQ-036 No presses -> time_left 3->2->1->0 at 4-cycle intervals; state=3, timeout=1 at the third wrap; disp_val=tries.
REQ-037 switch 8'h00->8'h81 in one cycle -> only index 0 processed, tries +1.
REQ-038 Winning press on the final wrap cycle -> state=2, time_left=1; reset asserted mid-PLAY -> all REQ-030 values next cycle.

Source files
------------

// File: rtl/lights_game_ctrl.sv
// -----------------------------------------------------------------------------
// lights_game_ctrl
//
// Controller for a "lights out" style game. A round starts from a
// pseudo-random lamp pattern taken from a free-running LFSR. Each rising edge
// on a player switch toggles that lamp and its two neighbours. The player wins
// by turning every lamp off before the countdown runs out.
//
// Handshake semantics: there is no valid/ready handshake. start is a level
// that is sampled every cycle and only acts outside PLAY. The switches are
// edge-detected internally. Only a 0->1 transition counts as a press.
//
// Ports
//   clk        in   1  rising-edge system clock
//   reset      in   1  synchronous, active-high reset
//   start      in   1  begin a new round (ignored while playing)
//   switch     in   8  player switches, already synchronous to clk
//   light      out  8  lamp pattern (registered)
//   tries      out  8  accepted presses this round, saturates at 99
//   time_left  out  8  remaining seconds (binary)
//   disp_val   out  8  value for the two-digit display decoder, 0..99
//   state      out  2  IDLE=0, PLAY=1, WIN=2, LOSE=3 (debug/observability)
//   finish     out  1  high while in WIN
//   timeout    out  1  high while in LOSE
// -----------------------------------------------------------------------------
module lights_game_ctrl #(
  parameter int TICK_CYCLES = 50000000,
  parameter int COUNTDOWN   = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] switch,
  output logic [7:0] light,
  output logic [7:0] tries,
  output logic [7:0] time_left,
  output logic [7:0] disp_val,
  output logic [1:0] state,
  output logic       finish,
  output logic       timeout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_WIN  = 2'd2,
    S_LOSE = 2'd3
  } state_t;

  localparam int            CW         = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] TICK_LAST  = CW'(TICK_CYCLES - 1);
  localparam logic [7:0]    COUNT_INIT = 8'(COUNTDOWN);
  localparam logic [7:0]    TRIES_MAX  = 8'd99;
  localparam logic [7:0]    LFSR_SEED  = 8'hA5;

  state_t        state_q, state_d;
  logic [7:0]    light_q, light_d;
  logic [7:0]    tries_q, tries_d;
  logic [7:0]    time_q, time_d;
  logic [7:0]    disp_q, disp_d;
  logic [CW-1:0] tick_q, tick_d;
  logic [7:0]    lfsr_q, lfsr_d;
  logic [7:0]    switch_q;

  logic [7:0] press;
  logic [7:0] press_low;
  logic [7:0] toggle_mask;
  logic [7:0] light_post;
  logic       press_any;
  logic       tick_wrap;

  // Rising-edge detect on the switches. switch_q resets to all ones so that
  // a switch held through reset is not seen as a press.
  assign press     = switch & ~switch_q;
  assign press_any = |press;

  // Isolate the lowest set bit (two's complement trick). The higher presses
  // in the same cycle are dropped.
  assign press_low = press & (~press + 8'd1);

  // Neighbour toggle. The shifts fall off the ends naturally, so lamp 0 has
  // no lower neighbour and lamp 7 has no upper neighbour.
  assign toggle_mask = press_low | (press_low << 1) | (press_low >> 1);
  assign light_post  = light_q ^ toggle_mask;

  assign tick_wrap = (tick_q == TICK_LAST);

  always_comb begin
    state_d = state_q;
    light_d = light_q;
    tries_d = tries_q;
    time_d  = time_q;
    tick_d  = '0;
    // Fibonacci LFSR, taps 8,6,5,4. It runs in every state, so the starting
    // pattern depends on when the player presses start.
    lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    case (state_q)
      S_PLAY: begin
        tick_d = tick_wrap ? '0 : tick_q + 1'b1;
        if (press_any) begin
          light_d = light_post;
          tries_d = (tries_q == TRIES_MAX) ? TRIES_MAX : tries_q + 8'd1;
        end
        // A winning press beats a timer expiry in the same cycle. time_left
        // is then left at its pre-wrap value.
        if (press_any && (light_post == 8'h00)) begin
          state_d = S_WIN;
          tick_d  = '0;
        end else if (tick_wrap) begin
          time_d = time_q - 8'd1;
          if (time_q == 8'd1) begin
            state_d = S_LOSE;
            tick_d  = '0;
          end
        end
      end
      default: begin
        // IDLE, WIN and LOSE: everything is frozen until start.
        if (start) begin
          state_d = S_PLAY;
          light_d = lfsr_q;
          tries_d = 8'd0;
          time_d  = COUNT_INIT;
        end
      end
    endcase

    // The display follows the registered sources, so it lags them by one cycle.
    case (state_q)
      S_IDLE:  disp_d = 8'd0;
      S_PLAY:  disp_d = time_q;
      default: disp_d = tries_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      light_q  <= 8'h00;
      tries_q  <= 8'd0;
      time_q   <= 8'd0;
      disp_q   <= 8'd0;
      tick_q   <= '0;
      lfsr_q   <= LFSR_SEED;
      switch_q <= 8'hFF;
    end else begin
      state_q  <= state_d;
      light_q  <= light_d;
      tries_q  <= tries_d;
      time_q   <= time_d;
      disp_q   <= disp_d;
      tick_q   <= tick_d;
      lfsr_q   <= lfsr_d;
      switch_q <= switch;
    end
  end

  assign light     = light_q;
  assign tries     = tries_q;
  assign time_left = time_q;
  assign disp_val  = disp_q;
  assign state     = state_q;
  assign finish    = (state_q == S_WIN);
  assign timeout   = (state_q == S_LOSE);

endmodule

// File: tb/tb_lights_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lights_game_ctrl
//
// Directed bench for lights_game_ctrl with TICK_CYCLES=4 and COUNTDOWN=3.
// Inputs are driven #1 after the rising edge and outputs are sampled at that
// same point. A small reference LFSR follows the documented polynomial, so
// rounds can be started on a chosen lamp pattern.
// -----------------------------------------------------------------------------
module tb_lights_game_ctrl;

  localparam int TICK_CYCLES = 4;
  localparam int COUNTDOWN   = 3;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] switch;
  logic [7:0] light, tries, time_left, disp_val;
  logic [1:0] state;
  logic       finish, timeout;

  always #5 clk = ~clk;

  lights_game_ctrl #(
    .TICK_CYCLES(TICK_CYCLES),
    .COUNTDOWN  (COUNTDOWN)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .switch   (switch),
    .light    (light),
    .tries    (tries),
    .time_left(time_left),
    .disp_val (disp_val),
    .state    (state),
    .finish   (finish),
    .timeout  (timeout)
  );

  // ---------------- reference LFSR ----------------
  // m_lfsr matches the DUT's LFSR right after an edge. m_prev holds the
  // value from before that edge, which is what a start pulse loads into light.
  logic [7:0] m_lfsr, m_prev;
  always @(posedge clk) begin
    m_prev <= m_lfsr;
    if (reset) m_lfsr <= 8'hA5;
    else       m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Wait until the DUT LFSR holds the target value, then pulse start so that
  // the target is loaded into light.
  task automatic start_on(input logic [7:0] target);
    int n;
    n = 0;
    while (m_lfsr != target && n < 300) begin
      step(1);
      n++;
    end
    check("lfsr_reach", 32'(n < 300), 32'd1);
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  logic [7:0] exp_light;

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    switch = 8'h00;
    step(2);

    // Reset values
    check("rst_state", state, 0);
    check("rst_light", light, 0);
    check("rst_tries", tries, 0);
    check("rst_time",  time_left, 0);
    check("rst_disp",  disp_val, 0);
    check("rst_finish", finish, 0);
    check("rst_timeout", timeout, 0);

    // Round 1: start right after reset, so light gets the seed 0xA5.
    reset = 1'b0;
    start = 1'b1;
    step(1);                                   // S0
    start = 1'b0;
    check("r1_state", state, 1);
    check("r1_light", light, 8'hA5);
    check("r1_tries", tries, 0);
    check("r1_time",  time_left, 3);
    switch = 8'h08;                            // press lamp 3 -> toggles 2,3,4
    step(1);                                   // S1
    switch = 8'h00;
    check("r1_press_light", light, 8'hB9);
    check("r1_press_tries", tries, 1);
    check("r1_disp_time", disp_val, 3);
    step(3);                                   // S4: first wrap
    check("r1_time_wrap1", time_left, 2);
    step(1);                                   // S5
    check("r1_disp_wrap1", disp_val, 2);
    start = 1'b1;                              // start ignored in PLAY
    step(1);                                   // S6
    start = 1'b0;
    check("r1_start_ign_state", state, 1);
    check("r1_start_ign_tries", tries, 1);
    check("r1_start_ign_time", time_left, 2);
    step(2);                                   // S8: second wrap
    check("r1_time_wrap2", time_left, 1);
    step(3);                                   // S11
    check("r1_state_pre", state, 1);
    step(1);                                   // S12: third wrap -> LOSE
    check("r1_lose_state", state, 3);
    check("r1_lose_timeout", timeout, 1);
    check("r1_lose_finish", finish, 0);
    check("r1_lose_time", time_left, 0);
    step(1);
    check("r1_lose_disp", disp_val, 1);
    switch = 8'h01;                            // press ignored in LOSE
    step(1);
    switch = 8'h00;
    check("r1_lose_frz_light", light, 8'hB9);
    check("r1_lose_frz_tries", tries, 1);

    // Round 2: light=0x02, press lamp 0, hold it, then a multi-bit press.
    start_on(8'h02);
    check("r2_light", light, 8'h02);
    switch = 8'h01;
    step(1);
    check("r2_press_light", light, 8'h01);
    check("r2_press_tries", tries, 1);
    step(2);                                   // switch held: no new press
    check("r2_hold_light", light, 8'h01);
    check("r2_hold_tries", tries, 1);
    switch = 8'h00;
    step(1);
    switch = 8'h81;                            // only lamp 0 processed
    step(1);
    switch = 8'h00;
    check("r2_multi_light", light, 8'h02);
    check("r2_multi_tries", tries, 2);
    step(7);                                   // S12 -> LOSE
    check("r2_lose_state", state, 3);

    // Round 3: light=0x07, press lamp 1 -> all off -> WIN.
    start_on(8'h07);
    check("r3_light", light, 8'h07);
    switch = 8'h02;
    step(1);
    switch = 8'h00;
    check("r3_win_light", light, 8'h00);
    check("r3_win_state", state, 2);
    check("r3_win_finish", finish, 1);
    check("r3_win_timeout", timeout, 0);
    check("r3_win_tries", tries, 1);
    step(1);
    check("r3_win_disp", disp_val, 1);
    switch = 8'h04;                            // press ignored in WIN
    step(2);
    switch = 8'h00;
    check("r3_frz_light", light, 8'h00);
    check("r3_frz_tries", tries, 1);
    check("r3_frz_state", state, 2);
    start = 1'b1;
    step(1);                                   // restart from WIN
    start = 1'b0;
    exp_light = m_prev;
    check("r3_restart_state", state, 1);
    check("r3_restart_tries", tries, 0);
    check("r3_restart_light", light, exp_light);
    check("r3_restart_nz", 32'(light != 8'h00), 1);
    step(12);
    check("r3_restart_lose", state, 3);

    // Round 4: winning press lands on the final wrap cycle.
    start_on(8'h07);
    step(11);                                  // S11: tick at last count
    check("r4_pre_time", time_left, 1);
    check("r4_pre_state", state, 1);
    switch = 8'h02;
    step(1);                                   // S12: press and wrap together
    switch = 8'h00;
    check("r4_win_state", state, 2);
    check("r4_win_time", time_left, 1);
    check("r4_win_light", light, 8'h00);
    check("r4_win_timeout", timeout, 0);

    // Round 5: reset aborts a round, and wins over start and a press.
    start = 1'b1;
    step(1);
    start = 1'b0;
    check("r5_state", state, 1);
    step(2);
    reset  = 1'b1;
    start  = 1'b1;
    switch = 8'h10;
    step(1);
    check("r5_rst_state", state, 0);
    check("r5_rst_light", light, 0);
    check("r5_rst_tries", tries, 0);
    check("r5_rst_time",  time_left, 0);
    check("r5_rst_disp",  disp_val, 0);
    check("r5_rst_finish", finish, 0);
    check("r5_rst_timeout", timeout, 0);
    reset = 1'b0;                              // start still high, switch held
    step(1);
    start = 1'b0;
    check("r5_seed_light", light, 8'hA5);
    check("r5_seed_state", state, 1);
    step(1);
    check("r5_held_tries", tries, 0);
    check("r5_held_light", light, 8'hA5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
